// File: rtl/spi_peripheral_if.sv
// SPI bus bundle between a host (master) and spi_peripheral (slave).
// The cipo return line exists only when READBACK_EN is defined.
interface spi_peripheral_if;
    logic sclk;
    logic copi;
    logic ncs;
`ifdef READBACK_EN
    logic cipo;

    modport master (output sclk, output copi, output ncs, input cipo);
    modport slave  (input sclk, input copi, input ncs, output cipo);
`else
    modport master (output sclk, output copi, output ncs);
    modport slave  (input sclk, input copi, input ncs);
`endif
endinterface

// File: rtl/spi_peripheral.sv
// SPI mode-0 target feeding a bank of nine 8-bit control registers.
// 16-bit frames {rw, addr[6:0], data[7:0]} are sampled through input
// synchronizers and committed atomically one clk after the synced ncs rise.
// Optional macro READBACK_EN adds register readback on cipo.
module spi_peripheral #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_peripheral_if.slave   spi,
    output logic [7:0]        reg_en_out,
    output logic [7:0]        reg_en_pwm_out,
    output logic [7:0]        reg_out_3_0_pwm_gen_channel,
    output logic [7:0]        reg_out_7_4_pwm_gen_channel,
    output logic [7:0]        reg_pwm_gen_0_ch_0_duty_cycle,
    output logic [7:0]        reg_pwm_gen_0_ch_1_duty_cycle,
    output logic [7:0]        reg_pwm_gen_1_ch_0_duty_cycle,
    output logic [7:0]        reg_pwm_gen_1_ch_1_duty_cycle,
    output logic [7:0]        reg_pwm_gen_1_0_frequency_divider
);
    localparam int         NUM_REGS   = 9;
    localparam logic [6:0] MAX_ADDR_L = 7'(MAX_ADDR);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
    logic [SYNC_STAGES-1:0] fill_q;       // marks stages holding real samples
    logic                   sclk_prev_q, ncs_prev_q;
    logic                   armed_q;      // ncs has been seen high since reset
    logic                   sclk_s, copi_s, ncs_s;
    logic                   sclk_rise, ncs_rise, ncs_fall;

    state_t                 state_q, state_d;
    logic [15:0]            shift_q, shift_d;
    logic [4:0]             cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic [6:0]             frame_addr;
    logic                   commit_ok;
    logic [7:0]             regs_q [NUM_REGS];

    // Input synchronizers, previous-value flops for edge detection, and arming.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '1;
            fill_q      <= '0;
            sclk_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b1;
            armed_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the old value of its neighbour, forming a real shift chain.
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], spi.copi};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], spi.ncs};
            fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            sclk_prev_q <= sclk_s;
            ncs_prev_q  <= ncs_s;
            // The reset value of ncs must not count as "seen high".
            armed_q     <= armed_q | (fill_q[SYNC_STAGES-1] & ncs_s);
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign copi_s    = copi_sync_q[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign ncs_rise  = ncs_s & ~ncs_prev_q;
    assign ncs_fall  = ~ncs_s & ncs_prev_q & armed_q;

    // Frame FSM state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic: start on ncs fall, shift on sclk rise, commit on ncs rise.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (ncs_fall) begin
                    state_d = SHIFT;
                    shift_d = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            SHIFT: begin
                // An ncs rise wins over a coincident sclk rise.
                if (ncs_rise) begin
                    state_d = COMMIT;
                end else if (sclk_rise) begin
                    shift_d = {shift_q[14:0], copi_s};
                    if (cnt_q == 5'd16) ovf_d = 1'b1;
                    else                cnt_d = cnt_q + 5'd1;
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign frame_addr = shift_q[14:8];
    assign commit_ok  = (state_q == COMMIT) && (cnt_q == 5'd16) && !ovf_q &&
                        shift_q[15] && (frame_addr <= MAX_ADDR_L);

    // Register bank: the addressed register takes the data byte at the end of COMMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this bank drives live control inputs, so each entry is a reset flop rather than RAM.
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (commit_ok) begin
            for (int i = 0; i < NUM_REGS; i++)
                if (frame_addr == 7'(i)) regs_q[i] <= shift_q[7:0];
        end
    end

    assign reg_en_out                        = regs_q[0];
    assign reg_en_pwm_out                    = regs_q[1];
    assign reg_out_3_0_pwm_gen_channel       = regs_q[2];
    assign reg_out_7_4_pwm_gen_channel       = regs_q[3];
    assign reg_pwm_gen_0_ch_0_duty_cycle     = regs_q[4];
    assign reg_pwm_gen_0_ch_1_duty_cycle     = regs_q[5];
    assign reg_pwm_gen_1_ch_0_duty_cycle     = regs_q[6];
    assign reg_pwm_gen_1_ch_1_duty_cycle     = regs_q[7];
    assign reg_pwm_gen_1_0_frequency_divider = regs_q[8];

`ifdef READBACK_EN
    logic       sclk_fall;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] tx_q, tx_d;

    assign sclk_fall = ~sclk_s & sclk_prev_q;
    // The header byte is complete in shift_d on the 8th sclk rise.
    assign rd_addr   = shift_d[6:0];

    // Readback mux over the register bank.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (rd_addr == 7'(i)) rd_data = regs_q[i];
    end

    // Output shifter: load on the 8th rise of a valid read, advance on each sclk fall.
    always_comb begin
        tx_d = tx_q;
        if (state_q != SHIFT || ncs_rise)
            tx_d = '0;
        else if (sclk_rise && cnt_q == 5'd7)
            tx_d = (!shift_d[7] && rd_addr <= MAX_ADDR_L) ? rd_data : 8'h00;
        else if (sclk_fall)
            tx_d = {tx_q[6:0], 1'b0};
    end

    // Output shift register; cipo comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_q <= '0;
        else        tx_q <= tx_d;
    end

    assign spi.cipo = tx_q[7];
`endif
endmodule

// File: tb/tb_spi_peripheral.sv
// Testbench for spi_peripheral: directed and randomized frames checked
// against a frame-level register model. Readback checks need READBACK_EN.
module tb_spi_peripheral;
    localparam int SYNC_STAGES = 2;
    localparam int MAX_ADDR    = 8;
    localparam int HALF        = 4;   // sclk half period in clk cycles

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    logic [7:0] model [9];
    logic [7:0] rx_byte;
    wire  [7:0] r0, r1, r2, r3, r4, r5, r6, r7, r8;

    spi_peripheral_if spi_if ();

    spi_peripheral #(.SYNC_STAGES(SYNC_STAGES), .MAX_ADDR(MAX_ADDR)) dut (
        .clk                               (clk),
        .rst_n                             (rst_n),
        .spi                               (spi_if),
        .reg_en_out                        (r0),
        .reg_en_pwm_out                    (r1),
        .reg_out_3_0_pwm_gen_channel       (r2),
        .reg_out_7_4_pwm_gen_channel       (r3),
        .reg_pwm_gen_0_ch_0_duty_cycle     (r4),
        .reg_pwm_gen_0_ch_1_duty_cycle     (r5),
        .reg_pwm_gen_1_ch_0_duty_cycle     (r6),
        .reg_pwm_gen_1_ch_1_duty_cycle     (r7),
        .reg_pwm_gen_1_0_frequency_divider (r8)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dut_reg(input int i);
        case (i)
            0: return r0;
            1: return r1;
            2: return r2;
            3: return r3;
            4: return r4;
            5: return r5;
            6: return r6;
            7: return r7;
            default: return r8;
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 9; i++)
            check($sformatf("%s_r%0d", tag, i), dut_reg(i), model[i]);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 9; i++) model[i] = 8'h00;
    endfunction

    // A frame lands only if it is exactly 16 bits, a write, and in range.
    function automatic void model_apply(input logic [15:0] w, input int nbits);
        if (nbits == 16 && w[15] && int'(w[14:8]) <= MAX_ADDR)
            model[int'(w[14:8])] = w[7:0];
    endfunction

    // Clock out bits [first, last) of a frame, MSB first; bits past 16 send 0.
    // cipo is sampled just before the falls following rises 8..15.
    task automatic bits_out(input logic [15:0] word, input int first, input int last);
        logic [16:0] w;
        w = {word, 1'b0};
        for (int i = first; i < last; i++) begin
            spi_if.copi = (i < 16) ? w[16-i] : 1'b0;
            repeat (HALF) @(negedge clk);
            spi_if.sclk = 1'b1;
            repeat (HALF) @(negedge clk);
`ifdef READBACK_EN
            if (i >= 7 && i <= 14) rx_byte[14-i] = spi_if.cipo;
`endif
            spi_if.sclk = 1'b0;
        end
    endtask

    // Whole frame; returns on the negedge where ncs is raised.
    task automatic frame(input logic [15:0] word, input int nbits);
        spi_if.ncs = 1'b0;
        repeat (HALF) @(negedge clk);
        bits_out(word, 0, nbits);
        repeat (HALF) @(negedge clk);
        spi_if.ncs = 1'b1;
    endtask

    task automatic send(input string tag, input logic [15:0] word, input int nbits);
        frame(word, nbits);
        model_apply(word, nbits);
        repeat (SYNC_STAGES + 4) @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        logic [15:0] w;
        int          nb;
        rst_n       = 1'b0;
        spi_if.sclk = 1'b0;
        spi_if.copi = 1'b0;
        spi_if.ncs  = 1'b1;
        rx_byte     = '0;
        model_reset();

        repeat (3) @(negedge clk);
        check_all("in_reset");
        rst_n = 1'b1;
        repeat (1000) @(negedge clk);
        check_all("idle_1000");

        // sclk activity with ncs high must be ignored
        for (int i = 0; i < 20; i++) begin
            spi_if.copi = 1'b1;
            spi_if.sclk = ~spi_if.sclk;
            repeat (HALF) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        check_all("sclk_ncs_high");

        // Commit latency: SYNC_STAGES+2 clks after the raw ncs rise
        frame(16'h8455, 16);
        repeat (SYNC_STAGES + 1) @(negedge clk);
        check("lat_before", r4, 8'h00);
        @(negedge clk);
        check("lat_after", r4, 8'h55);
        model_apply(16'h8455, 16);
        check_all("w8455");

        send("short15", 16'h80FF, 15);
        send("long17",  16'h80FF, 17);
        send("w80a5",   16'h80A5, 16);
        send("oor89",   16'h8912, 16);
        send("rd0033",  16'h0033, 16);

`ifdef READBACK_EN
        send("w81c3", 16'h81C3, 16);
        send("rd0100", 16'h0100, 16);
        check("cipo_rd01", rx_byte, 8'hC3);
`endif

        // Reset in the middle of a frame, released with ncs still low
        spi_if.ncs = 1'b0;
        repeat (HALF) @(negedge clk);
        bits_out(16'h8877, 0, 10);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("mid_reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        bits_out(16'h8877, 10, 16);
        repeat (HALF) @(negedge clk);
        spi_if.ncs = 1'b1;
        repeat (SYNC_STAGES + 4) @(negedge clk);
        check_all("tail_no_commit");
        send("w8877", 16'h8877, 16);

        // Reset released with ncs low, then a full valid frame: must not start
        spi_if.ncs = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        bits_out(16'h8123, 0, 16);
        repeat (HALF) @(negedge clk);
        spi_if.ncs = 1'b1;
        repeat (SYNC_STAGES + 4) @(negedge clk);
        check_all("ncs_low_at_release");

        // Back-to-back writes with 2 clks of ncs high between them
        frame(16'h883C, 16);
        repeat (2) @(negedge clk);
        frame(16'h82E4, 16);
        model_apply(16'h883C, 16);
        model_apply(16'h82E4, 16);
        repeat (SYNC_STAGES + 4) @(negedge clk);
        check_all("b2b");

        // Randomized frames: lengths 15/16/17, reads and writes, some out of range
        for (int n = 0; n < 24; n++) begin
            w[15]   = 1'($urandom_range(0, 1));
            w[14:8] = 7'($urandom_range(0, 11));
            w[7:0]  = 8'($urandom);
            case ($urandom_range(0, 4))
                0:       nb = 15;
                4:       nb = 17;
                default: nb = 16;
            endcase
            send($sformatf("rnd%0d", n), w, nb);
`ifdef READBACK_EN
            if (nb == 16 && !w[15] && int'(w[14:8]) <= MAX_ADDR)
                check($sformatf("rnd%0d_cipo", n), rx_byte, model[int'(w[14:8])]);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
